// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus key event outputs of keypad_scanner.
interface keypad_scanner_if;
   logic [3:0] row_out;
   logic [3:0] col_in;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   modport master (output row_out, key_code, key_valid, key_held, input col_in);
   modport slave (input row_out, key_code, key_valid, key_held, output col_in);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans and debounces a 4x4 active-low keypad, one key_code per press.
// Defining KEYPAD_REPEAT_EN adds auto-repeat of key_valid while a key stays held.
module keypad_scanner #(
   parameter int SCAN_DIV     = 6000,
   parameter int DEBOUNCE_CNT = 5,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input logic              clk,
   input logic              reset_in,
   keypad_scanner_if.master kp
);
   localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
   // nibble {row, col} holds the code of that key
   localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    col_s1_q, col_s2_q, col_low;
   logic [1:0]    row_q, row_d, cand_q, cand_d, first_col;
   logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
   logic          tick, cand_low, accept, rep_hit;
   assign col_low   = ~col_s2_q;
   assign tick      = div_q == DIV_MAX;
   assign div_d     = tick ? '0 : div_q + DW'(1);
   assign first_col = col_low[0] ? 2'd0 : col_low[1] ? 2'd1 : col_low[2] ? 2'd2 : 2'd3;
   assign cand_low  = col_low[cand_q];
   assign accept    = state_q != HELD && state_d == HELD;
   assign kp.row_out   = ~(4'b0001 << row_q);
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;
   always_ff @(posedge clk or posedge reset_in)
      if (reset_in) state_q <= SCAN;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (|col_low) begin
                  cand_d  = first_col;
                  cnt_d   = CW'(1);
                  state_d = cnt_d == CNT_MAX ? HELD : DEBOUNCE;
               end else row_d = row_q + 2'd1;
            end
            DEBOUNCE: begin
               if (cand_low) begin
                  cnt_d   = cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1);
                  state_d = cnt_d == CNT_MAX ? HELD : DEBOUNCE;
               end else begin
                  state_d = SCAN;
                  row_d   = row_q + 2'd1;
                  cnt_d   = '0;
               end
            end
            HELD: begin
               rel_d = cand_low ? '0 : rel_q == CNT_MAX ? rel_q : rel_q + CW'(1);
               if (rel_d == CNT_MAX) begin
                  state_d = SCAN;
                  row_d   = row_q + 2'd1;
                  rel_d   = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end
`ifdef KEYPAD_REPEAT_EN
   localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE);
   logic [RW-1:0] rep_q, rep_d;
   logic          rep_first_q, rep_first_d;
   // any release sample restarts the repeat schedule from the initial delay
   always_comb begin
      rep_d       = rep_q;
      rep_first_d = rep_first_q;
      rep_hit     = 1'b0;
      if (state_q != HELD || (tick && !cand_low)) begin
         rep_d       = '0;
         rep_first_d = 1'b1;
      end else if (tick) begin
         rep_d = rep_q + RW'(1);
         if (rep_d == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
            rep_hit     = 1'b1;
            rep_d       = '0;
            rep_first_d = 1'b0;
         end
      end
   end
   always_ff @(posedge clk or posedge reset_in)
      if (reset_in) begin
         rep_q       <= '0;
         rep_first_q <= 1'b1;
      end else begin
         rep_q       <= rep_d;
         rep_first_q <= rep_first_d;
      end
`else
   assign rep_hit = 1'b0;
`endif
   always_comb begin
      key_valid_d = accept || rep_hit;
      key_code_d  = accept ? KEYMAP[{row_q, cand_d, 2'b00} +: 4] : key_code_q;
      key_held_d  = state_d == HELD;
   end
   always_ff @(posedge clk or posedge reset_in)
      if (reset_in) begin
         div_q       <= '0;
         col_s1_q    <= 4'hF;
         col_s2_q    <= 4'hF;
         row_q       <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         rel_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         div_q       <= div_d;
         col_s1_q    <= kp.col_in;
         col_s2_q    <= col_s1_q;
         row_q       <= row_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         rel_q       <= rel_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, tick-level behavioural reference and directed scenarios.
module tb_keypad_scanner;
   localparam int DIV = 4, DB = 3, RD = 10, RR = 4;
   logic clk = 1'b0;
   logic reset_in = 1'b1;
   logic [3:0] pressed [4];
   int checks = 0, failures = 0, vcnt = 0, v0;
   logic [3:0] last_code = '0;
   bit run = 1'b0;
   keypad_scanner_if kp();
   keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR))
      dut (.clk(clk), .reset_in(reset_in), .kp(kp));
   always #5 clk = ~clk;
   // a pressed key shorts its column to its row while that row is driven low
   always_comb begin
      kp.col_in = 4'hF;
      for (int r = 0; r < 4; r++) if (!kp.row_out[r]) kp.col_in = kp.col_in & ~pressed[r];
   end
   typedef struct {
      int div; int row; int mode; int col; int cnt; int rel; int rep;
      logic [3:0] code; bit valid;
   } mdl_t;
   mdl_t m;
   function automatic logic [3:0] legend_code(int r, int c);
      string legend;
      byte ch;
      legend = "123A456B789C*0#D";
      ch = legend[r * 4 + c];
      return ch == "*" ? 4'hE : ch == "#" ? 4'hF : ch >= "A" ? 4'(ch - 8'd55) : 4'(ch - 8'd48);
   endfunction
   function automatic int lowest(logic [3:0] cols);
      int l = 0;
      for (int c = 3; c >= 0; c--) if (cols[c]) l = c;
      return l;
   endfunction
   // mode: 0 idle scanning, 1 collecting press samples, 2 key accepted and held
   function automatic mdl_t step(mdl_t s, logic [3:0] cols);
      mdl_t n = s;
      n.valid = 1'b0;
      n.div = (s.div + 1) % DIV;
      if (s.div != DIV - 1) return n;
      if (s.mode == 0) begin
         if (cols != 0) begin
            n.col = lowest(cols); n.cnt = 1; n.mode = 1;
         end else n.row = (s.row + 1) % 4;
      end else if (s.mode == 1) begin
         if (cols[s.col]) begin
            n.cnt = s.cnt + 1;
            if (n.cnt == DB) begin
               n.mode = 2; n.valid = 1'b1; n.code = legend_code(s.row, s.col); n.rel = 0; n.rep = 0;
            end
         end else begin
            n.mode = 0; n.row = (s.row + 1) % 4;
         end
      end else if (!cols[s.col]) begin
         n.rel = s.rel + 1; n.rep = 0;
         if (n.rel == DB) begin
            n.mode = 0; n.row = (s.row + 1) % 4;
         end
      end else begin
         n.rel = 0;
`ifdef KEYPAD_REPEAT_EN
         n.rep = s.rep + 1;
         n.valid = n.rep == RD || (n.rep > RD && (n.rep - RD) % RR == 0);
`endif
      end
      return n;
   endfunction
   always @(posedge clk or posedge reset_in)
      if (reset_in) m <= '{default: 0};
      else m <= step(m, pressed[m.row]);
   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk)
      if (run && !reset_in) begin
         chk("row_out", kp.row_out, 4'b1111 ^ (4'b0001 << m.row));
         chk("key_valid", kp.key_valid, m.valid);
         chk("key_code", kp.key_code, m.code);
         chk("key_held", kp.key_held, m.mode == 2);
      end
   always @(negedge clk)
      if (kp.key_valid === 1'b1) begin
         vcnt <= vcnt + 1;
         last_code <= kp.key_code;
      end
   task automatic ticks(int n);
      repeat (n * DIV) @(negedge clk);
      #1;
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset_in = 1'b1;
      for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
      repeat (2) @(negedge clk);
      reset_in = 1'b0;
      #1;
   endtask
   initial begin
      for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
      do_reset();
      run = 1'b1;
      chk("s1_row0", kp.row_out, 4'b1110);
      ticks(1); chk("s1_row1", kp.row_out, 4'b1101);
      ticks(1); chk("s1_row2", kp.row_out, 4'b1011);
      ticks(1); chk("s1_row3", kp.row_out, 4'b0111);
      ticks(1); chk("s1_wrap", kp.row_out, 4'b1110);
      ticks(4);
      chk("s1_no_valid", 8'(vcnt), 8'd0);
      chk("s1_held", kp.key_held, 1'b0);
      v0 = vcnt;
      pressed[1] = 4'b0100;
      ticks(20);
      chk("s2_held_on", kp.key_held, 1'b1);
      pressed[1] = 4'h0;
      ticks(2); chk("s2_held_2rel", kp.key_held, 1'b1);
      ticks(1); chk("s2_held_off", kp.key_held, 1'b0);
      chk("s2_one_valid", 8'(vcnt - v0), 8'd1);
      chk("s2_code", last_code, 4'h6);
      ticks(4);
      do_reset();
      v0 = vcnt;
      pressed[0] = 4'b0001;
      ticks(2);
      pressed[0] = 4'h0;
      ticks(1);
      chk("s3_row_adv", kp.row_out, 4'b1101);
      chk("s3_no_valid", 8'(vcnt - v0), 8'd0);
      chk("s3_held", kp.key_held, 1'b0);
      do_reset();
      v0 = vcnt;
      pressed[3] = 4'b0101;
      ticks(7);
      chk("s4_code", last_code, 4'hE);
      chk("s4_one_valid", 8'(vcnt - v0), 8'd1);
      pressed[1] = 4'b0010;
      ticks(6);
      chk("s4_ignored", 8'(vcnt - v0), 8'd1);
      pressed[3] = 4'h0;
      ticks(9);
      chk("s4_fresh_code", last_code, 4'h5);
      chk("s4_fresh_valid", 8'(vcnt - v0), 8'd2);
      pressed[1] = 4'h0;
      ticks(4);
      reset_in = 1'b1;
      #1;
      chk("s5_async_code", kp.key_code, 4'h0);
      do_reset();
      v0 = vcnt;
      pressed[2] = 4'b0100;
      ticks(4);
      @(negedge clk);
      reset_in = 1'b1;
      #1;
      chk("s5_row", kp.row_out, 4'b1110);
      chk("s5_valid", kp.key_valid, 1'b0);
      chk("s5_held", kp.key_held, 1'b0);
      repeat (8) @(negedge clk);
      pressed[2] = 4'h0;
      reset_in = 1'b0;
      #1;
      chk("s5_no_valid", 8'(vcnt - v0), 8'd0);
      chk("s5_restart", kp.row_out, 4'b1110);
      ticks(2);
      do_reset();
      v0 = vcnt;
      pressed[3] = 4'b0010;
      ticks(36);
      pressed[3] = 4'h0;
      ticks(5);
`ifdef KEYPAD_REPEAT_EN
      chk("s6_pulses", 8'(vcnt - v0), 8'd7);
`else
      chk("s6_pulses", 8'(vcnt - v0), 8'd1);
`endif
      chk("s6_code", last_code, 4'h0);
      chk("s6_held", kp.key_held, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad, debounces it, and delivers one 4-bit key code per press to the main control FSM.
- Sits directly upstream of fsm_module and owns the four row-drive outputs and four column-sense inputs.
- Single press per event; no buffering beyond the current key code.

Parameters:
SCAN_DIV, 6000, clk cycles per row slot and per debounce sample tick (1 ms at 6 MHz HFOSC)
DEBOUNCE_CNT, 5, consecutive identical samples required to accept a press or a release
REPEAT_DELAY, 500, ticks held before the first auto-repeat (only used with KEYPAD_REPEAT_EN)
REPEAT_RATE, 100, ticks between subsequent auto-repeats (only used with KEYPAD_REPEAT_EN)

Ports:
clk  input  1  system clock, single domain
reset_in  input  1  asynchronous, active-high reset
row_out  output  4  row drive, active-low, exactly one bit low at all times
col_in  input  4  column sense, active-low, externally pulled up, asynchronous
key_code  output  4  code of the last accepted key; stable until the next acceptance
key_valid  output  1  one-cycle strobe, key_code valid in the same cycle
key_held  output  1  high from acceptance until release is accepted

Behaviour:
- Reset values: row_out=4'b1110 (row 0), key_code=0, key_valid=0, key_held=0, FSM=SCAN, all counters=0.
- col_in passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Tick: free-running divider counts 0..SCAN_DIV-1. Tick asserts on the cycle the count equals SCAN_DIV-1. Columns are sampled only on tick.
- Key map: row r, column c (row_out[r], col_in[c]).
  - Row 0: 1,2,3,A -> 0x1,0x2,0x3,0xA
  - Row 1: 4,5,6,B -> 0x4,0x5,0x6,0xB
  - Row 2: 7,8,9,C -> 0x7,0x8,0x9,0xC
  - Row 3: *,0,#,D -> 0xE,0x0,0xF,0xD
- Multiple columns low: the lowest column index wins.
- FSM:
  - SCAN: on tick, if any column is low, latch row/col candidate, set cnt=1, go to DEBOUNCE, keep the row. Otherwise advance the row 0->1->2->3->0.
  - DEBOUNCE: row frozen.
    - On tick, same candidate column low: cnt++.
    - On tick, candidate not low: go to SCAN and advance the row.
    - When cnt reaches DEBOUNCE_CNT: next cycle key_code<=code, key_valid=1 for 1 cycle, key_held=1, go to HELD.
  - HELD: row frozen.
    - On tick, candidate column high: rel_cnt++; otherwise rel_cnt=0.
    - At rel_cnt=DEBOUNCE_CNT: key_held=0, go to SCAN, advance the row.
    - Other keys pressed while HELD are ignored. A second key still pressed after release is detected as a fresh press.
- Latency: key_valid rises exactly 1 clk after the tick carrying the DEBOUNCE_CNT-th matching sample.
- Reset asserted mid-operation: all state returns immediately to the reset values; no key_valid is emitted.
- Counters saturate; the divider wraps.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter counts ticks while the key stays pressed.
  - At REPEAT_DELAY ticks, key_valid pulses again with the same key_code.
  - After that, it pulses every REPEAT_RATE ticks until release starts.
  - Any release sample resets the repeat counter.
- Undefined: exactly one key_valid per press. REPEAT_* parameters are ignored and no repeat logic is synthesized.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.
1. Reset, no keys -> row_out cycles 1110,1101,1011,0111 changing every 4 clk; key_valid never asserts; key_held=0.
2. Press row1/col2 clean for 20 ticks, then release -> exactly one key_valid with key_code=0x6; key_held high until 3 release ticks have elapsed, then 0; scanning resumes.
3. Row0/col0 low for 2 ticks, then high (bounce) -> no key_valid; FSM returns to SCAN and row advances to row 1.
4. Row3/col0 and row3/col2 low together -> key_code=0xE (lowest column wins); a second key in another row pressed during HELD gives no extra key_valid.
5. Assert reset_in in the middle of DEBOUNCE of key 0x9 -> outputs immediately take reset values; key_valid stays 0; after deassert, scanning restarts at row 0.
6. With KEYPAD_REPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=4, hold 0x0 for 30 ticks -> key_valid pulses at acceptance, +10 ticks, then every 4 ticks; all pulses carry key_code=0x0.
